cdc_fifo_writer: RTL

Write-domain producer front end for the async CDC FIFO.
- Accepts a valid/ready stream from upstream logic and buffers up to 2 words in a skid buffer.
- Drives the FIFO write-pointer block (w_inc) and the dual-port memory write port (w_data), honouring w_full and optionally w_almost_full.
- Keeps write and stall statistics for debug and bring-up.
- Sits between user logic and the FIFO write-pointer/full logic, entirely in the w_clk domain.

---
 rtl/cdc_fifo_writer_pkg.sv | 15 +
 rtl/cdc_fifo_writer_skid_buf2.sv | 103 ++++++++++
 rtl/cdc_fifo_writer.sv | 62 ++++++
 3 files changed

// File: rtl/cdc_fifo_writer_pkg.sv
// Shared definitions for the CDC FIFO write-side front end:
// occupancy state encodings and a small state decode helper.
package cdc_fifo_writer_pkg;

  // Occupancy of the two-entry skid buffer
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // True when the buffer holds at least one word
  function automatic logic is_occupied(input logic [1:0] st);
    return (st != EMPTY);
  endfunction

endpackage

// File: rtl/cdc_fifo_writer_skid_buf2.sv
// Two-entry skid buffer with an occupancy FSM.
// The head entry drives out_data; the skid entry catches the word that
// arrives while the head is stalled. in_ready is registered and computed
// from the next occupancy so the upstream sees no combinational path.
module skid_buf2
  import cdc_fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  hold_off,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  ready_r;
  logic                  ready_nxt_s;
  logic                  busy_r;
  logic                  accept_s;
  logic                  pop_s;

  assign out_valid = is_occupied(state_r);
  assign pop_s     = out_valid & out_ready;
  assign accept_s  = in_valid & ready_r;
  assign in_ready  = ready_r;
  assign out_data  = head_r;
  assign busy      = busy_r;

  // Next occupancy from accept/pop; TWO never accepts since ready is low there
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_nxt_s = ONE;
        else          state_nxt_s = EMPTY;
      end
      ONE: begin
        if (accept_s && !pop_s)      state_nxt_s = TWO;
        else if (pop_s && !accept_s) state_nxt_s = EMPTY;
        else                         state_nxt_s = ONE;
      end
      TWO: begin
        if (pop_s) state_nxt_s = ONE;
        else       state_nxt_s = TWO;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Ready for next cycle: room left, optionally held off while anything is buffered
  always_comb begin
    ready_nxt_s = (state_nxt_s != TWO);
    if (hold_off && is_occupied(state_nxt_s)) begin
      ready_nxt_s = 1'b0;
    end else begin
      ready_nxt_s = ready_nxt_s;
    end
  end

  // Occupancy, ready and busy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= ready_nxt_s;
      busy_r  <= is_occupied(state_nxt_s);
    end
  end

  // Head entry: refilled from skid when draining TWO, else from input when head frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
    end else if (pop_s && (state_r == TWO)) begin
      head_r <= skid_r;
    end else if (accept_s && ((state_r == EMPTY) || pop_s)) begin
      head_r <= in_data;
    end
  end

  // Skid entry: catches a word arriving while the head is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r <= '0;
    end else if (accept_s && (state_r == ONE) && !pop_s) begin
      skid_r <= in_data;
    end
  end

endmodule

// File: rtl/cdc_fifo_writer.sv
// Write-domain producer front end for the async CDC FIFO.
// Buffers the upstream stream in a two-entry skid buffer, drives the FIFO
// write strobe/data while honouring w_full, and keeps write/stall statistics.
module cdc_fifo_writer
  import cdc_fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_W    = 16,
  parameter int EARLY_BP   = 0
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  w_full,
  input  logic                  w_almost_full,
  output logic                  w_inc,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_busy,
  output logic [COUNT_W-1:0]    w_wr_count,
  output logic [COUNT_W-1:0]    w_stall_count
);

  logic pending_s;
  logic hold_off_s;

  // Early back-pressure only when enabled; w_full is already registered upstream
  assign hold_off_s = (EARLY_BP != 0) ? w_almost_full : 1'b0;
  assign w_inc      = pending_s & ~w_full;

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (w_clk),
    .rst_n     (w_rst_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   (s_data),
    .hold_off  (hold_off_s),
    .out_valid (pending_s),
    .out_ready (~w_full),
    .out_data  (w_data),
    .busy      (w_busy)
  );

  // Write and stall statistics, wrapping modulo 2^COUNT_W
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_wr_count    <= '0;
      w_stall_count <= '0;
    end else begin
      if (w_inc) begin
        w_wr_count <= w_wr_count + COUNT_W'(1);
      end
      if (pending_s && w_full) begin
        w_stall_count <= w_stall_count + COUNT_W'(1);
      end
    end
  end

endmodule
